tft_lcd_timing: RTL and testbench
=================================

Name: tft_lcd_timing

Overview:
Parametrised timing generator for parallel RGB TFT panels. It replaces the fixed 480x272 generator, and every panel geometry and sync polarity is a parameter. It adds:
- a frame-boundary run/stop control,
- a frame counter,
- a PREFETCH lead so that pipelined pixel sources (pattern, framebuffer) line up with the data-enable.
It sits in the panel pixel-clock domain, after the PLL, and drives the lcd_en/hsync/vsync pins. The pixel colour logic consumes its coordinates.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch in clocks
- H_SYNC, 41, hsync width in clocks
- H_BP, 2, horizontal back porch in clocks
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch in lines
- V_SYNC, 10, vsync width in lines
- V_BP, 2, vertical back porch in lines
- HSYNC_POL, 0, active level of out_hsync (0 = active low)
- VSYNC_POL, 0, active level of out_vsync
- PREFETCH, 0, number of clocks that coordinates lead out_en/sync (range 0..7)
- COORD_W, 10, width of the coordinate and counter fields
- FRAME_W, 8, width of the frame counter

Ports:
- in_clk, input, 1, pixel clock
- in_rst_n, input, 1, asynchronous active-low reset
- in_run, input, 1, run request; stop only takes effect at a frame boundary
- out_pix_req, output, 1, coordinates valid (active area), PREFETCH clocks ahead of out_en
- out_pixelx, output, COORD_W, active x; 0 when out_pix_req is low
- out_pixely, output, COORD_W, active y; 0 when out_pix_req is low
- out_en, output, 1, panel data enable
- out_hsync, output, 1, hsync at HSYNC_POL
- out_vsync, output, 1, vsync at VSYNC_POL
- out_ssync, output, 1, one-clock start-of-frame pulse, aligned with out_en/sync
- out_frame, output, FRAME_W, completed-frame count (wraps)
- out_busy, output, 1, high while in RUN

Behaviour:
- Constants:
  - H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP
  - V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP
  - Elaboration error if 2^COORD_W < max(H_TOTAL, V_TOTAL), or if PREFETCH > 7.
- Counters hc and vc:
  - hc counts 0..H_TOTAL-1.
  - vc increments when hc wraps, and wraps at V_TOTAL-1.
  - Segment order within each axis: sync, back porch, active, front porch.
- Active-area decode:
  - ha = hc in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1].
  - va is the same decode on vc.
  - x = hc - (H_SYNC+H_BP); y = vc - (V_SYNC+V_BP).
- FSM states:
  - IDLE to RUN: when in_run=1. hc=vc=0 on the first RUN clock.
  - RUN to IDLE: when in_run=0 is sampled on the last pixel of a frame (hc=H_TOTAL-1 and vc=V_TOTAL-1). Counters go to 0.
  - in_run=0 mid-frame is ignored until that frame ends.
  - RUN with in_run=1 at frame end wraps straight into the next frame, with no gap.
  - Counters hold at 0 in IDLE.
- Stage 1 (registered, latency 1 from the counters):
  - out_pix_req = RUN & ha & va.
  - out_pixelx and out_pixely take x and y when out_pix_req is high, otherwise 0.
- Stage 2 (stage-1 decode delayed by PREFETCH further clocks through a shift register; PREFETCH=0 gives the same clock as stage 1):
  - out_en = RUN & ha & va.
  - out_hsync = active when RUN and hc < H_SYNC.
  - out_vsync = active when RUN and vc < V_SYNC.
  - out_ssync = RUN & hc==0 & vc==0.
- out_frame increments on the clock where the last pixel of a frame completes, whether the next state is RUN or IDLE. It wraps modulo 2^FRAME_W.
- Leaving RUN: the stage-2 pipeline drains normally. Nothing is truncated and no glitches occur.
- Reset (async assert, sync-free release):
  - State = IDLE; hc, vc, out_frame = 0.
  - Shift register cleared; out_pix_req, out_en, out_ssync = 0; coordinates = 0.
  - out_hsync = ~HSYNC_POL; out_vsync = ~VSYNC_POL; out_busy = 0.
  - Reset mid-line takes effect immediately, with no clock edge required.

Decomposition:
- Shared package lcd_timing_pkg:
  - derived-total functions (H_TOTAL/V_TOTAL from the porch parameters);
  - state enum (IDLE, RUN);
  - named timing constant sets for the 480x272 and 800x480 panels.
- One sub-module, lcd_delay_line: a parametrised-depth, per-bit shift register with async active-low reset and a per-bit reset value. It is used for the stage-2 alignment.

Test Plan:
1. Defaults, in_run=1 after reset → out_hsync low for 41 clocks every 525 clocks; out_vsync low for 10 lines every 150150 clocks; out_en high 480 clocks per line.
2. Small geometry (H: 4/1/2/1, V: 3/1/1/1; totals 8 and 6), PREFETCH=0 → out_en high for 4 clocks per line on 3 lines, 12 per 48-clock frame; out_pixelx 0,1,2,3; out_pixely 0..2; out_ssync one pulse per 48 clocks, on the same clock as the out_vsync assert.
3. Small geometry, PREFETCH=3 → out_pix_req rises exactly 3 clocks before out_en. The coordinates at each out_pix_req cycle match the x/y sequence of test 2.
4. Drop in_run at hc=2, vc=1 → the frame completes (12 out_en cycles total). out_frame increments once, then out_busy=0, out_en=0, syncs inactive. Raising in_run restarts at hc=vc=0.
5. Assert in_rst_n mid-active line with no clock edge → out_en=0, out_hsync=~HSYNC_POL, out_frame=0 immediately. After release with in_run=0 the block stays IDLE.
6. HSYNC_POL=1, VSYNC_POL=1 → syncs low in reset and IDLE, high for 2 clocks and 1 line respectively. Run 260 frames with FRAME_W=8 → out_frame wraps 255→0.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// ---------------------------------------------------------------------------
// lcd_timing_pkg
// Shared definitions for the parallel-RGB TFT timing generator:
//   - lcd_state_e : run/stop state of the generator
//   - lcd_axis_t  : one axis of panel geometry (active, porches, sync)
//   - axis_total  : total clocks/lines of one axis
//   - max2        : helper used for the coordinate-width elaboration check
//   - LCD480_H/V, LCD800_H/V : named geometry sets for common panels
// ---------------------------------------------------------------------------
package lcd_timing_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } lcd_state_e;

   typedef struct packed {
      int active;
      int fp;
      int sync;
      int bp;
   } lcd_axis_t;

   // Segment order on each axis is sync, back porch, active, front porch.
   function automatic int axis_total(input int active, input int fp,
                                     input int sync, input int bp);
      return sync + bp + active + fp;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // 4.3" 480x272 panel
   localparam lcd_axis_t LCD480_H = '{active: 480, fp: 2,  sync: 41, bp: 2};
   localparam lcd_axis_t LCD480_V = '{active: 272, fp: 2,  sync: 10, bp: 2};

   // 5"/7" 800x480 panel
   localparam lcd_axis_t LCD800_H = '{active: 800, fp: 40, sync: 48, bp: 88};
   localparam lcd_axis_t LCD800_V = '{active: 480, fp: 13, sync: 3,  bp: 32};

endpackage

// File: rtl/lcd_delay_line.sv
// ---------------------------------------------------------------------------
// lcd_delay_line
// Per-bit shift register of DEPTH stages with a per-bit reset value. Used to
// hold the panel-facing decode back so it lines up with prefetched pixels.
//   in_clk   : clock
//   in_rst_n : asynchronous active-low reset, loads RST_VAL into every stage
//   in_data  : WIDTH-bit input
//   out_data : in_data delayed by DEPTH clocks (DEPTH >= 1)
// ---------------------------------------------------------------------------
module lcd_delay_line #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] out_data
);

   if (DEPTH < 1) begin : g_bad_depth
      $error("lcd_delay_line: DEPTH must be at least 1");
   end

   logic [WIDTH-1:0] taps [DEPTH];

   // NOTE: every tap is reset, not just the output stage -- otherwise stale
   // pin levels would shift out for DEPTH clocks after reset release.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         for (int i = 0; i < DEPTH; i++) taps[i] <= RST_VAL;
      end else begin
         taps[0] <= in_data;
         for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
      end
   end

   assign out_data = taps[DEPTH-1];

endmodule

// File: rtl/tft_lcd_timing.sv
// ---------------------------------------------------------------------------
// tft_lcd_timing
// Parametrised timing generator for parallel RGB TFT panels, pixel-clock
// domain. Pixel coordinates lead the panel data-enable by PREFETCH clocks so
// a pipelined pixel source lines up with out_en.
//   in_clk      : pixel clock
//   in_rst_n    : asynchronous active-low reset
//   in_run      : run request; a stop only takes effect at a frame boundary
//   out_pix_req : coordinates valid (active area), PREFETCH clocks before out_en
//   out_pixelx  : active x, 0 outside the active area
//   out_pixely  : active y, 0 outside the active area
//   out_en      : panel data enable
//   out_hsync   : horizontal sync, active at HSYNC_POL
//   out_vsync   : vertical sync, active at VSYNC_POL
//   out_ssync   : one-clock start-of-frame pulse, aligned with out_en/syncs
//   out_frame   : completed-frame count, wraps
//   out_busy    : high while running
// ---------------------------------------------------------------------------
module tft_lcd_timing
   import lcd_timing_pkg::*;
#(
   parameter int H_ACTIVE  = LCD480_H.active,
   parameter int H_FP      = LCD480_H.fp,
   parameter int H_SYNC    = LCD480_H.sync,
   parameter int H_BP      = LCD480_H.bp,
   parameter int V_ACTIVE  = LCD480_V.active,
   parameter int V_FP      = LCD480_V.fp,
   parameter int V_SYNC    = LCD480_V.sync,
   parameter int V_BP      = LCD480_V.bp,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int PREFETCH  = 0,
   parameter int COORD_W   = 10,
   parameter int FRAME_W   = 8
) (
   input  logic               in_clk,
   input  logic               in_rst_n,
   input  logic               in_run,
   output logic               out_pix_req,
   output logic [COORD_W-1:0] out_pixelx,
   output logic [COORD_W-1:0] out_pixely,
   output logic               out_en,
   output logic               out_hsync,
   output logic               out_vsync,
   output logic               out_ssync,
   output logic [FRAME_W-1:0] out_frame,
   output logic               out_busy
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (PREFETCH < 0 || PREFETCH > 7) begin : g_bad_prefetch
      $error("tft_lcd_timing: PREFETCH must be in 0..7");
   end

   if (COORD_W < 32 && (64'd1 << COORD_W) < 64'(max2(H_TOTAL, V_TOTAL)))
   begin : g_bad_coord_w
      $error("tft_lcd_timing: COORD_W too narrow for H_TOTAL/V_TOTAL");
   end

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_ACT_LO = COORD_W'(H_SYNC + H_BP);
   localparam logic [COORD_W-1:0] H_ACT_HI = COORD_W'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] V_ACT_LO = COORD_W'(V_SYNC + V_BP);
   localparam logic [COORD_W-1:0] V_ACT_HI = COORD_W'(V_SYNC + V_BP + V_ACTIVE - 1);
   localparam logic [COORD_W-1:0] H_SYNC_N = COORD_W'(H_SYNC);
   localparam logic [COORD_W-1:0] V_SYNC_N = COORD_W'(V_SYNC);

   // Panel-facing decode: {en, hsync pin, vsync pin, ssync}. Sync bits are
   // carried as pin levels so the delay line can reset them to inactive.
   localparam logic [3:0] ALIGN_RST = {1'b0, ~HSYNC_POL, ~VSYNC_POL, 1'b0};

   lcd_state_e         state, state_nxt;
   logic [COORD_W-1:0] hc, vc, hc_nxt, vc_nxt;
   logic               running, frame_end, ha, va, pix_act;
   logic [3:0]         align_in, align_out;

   assign running   = (state == ST_RUN);
   assign frame_end = running && (hc == H_LAST) && (vc == V_LAST);

   // NOTE: state and counters use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state <= ST_IDLE;
         hc    <= '0;
         vc    <= '0;
      end else begin
         state <= state_nxt;
         hc    <= hc_nxt;
         vc    <= vc_nxt;
      end
   end

   // Counters sit at 0 in IDLE, so the first RUN clock is always hc=vc=0.
   // A stop request is only honoured on the last pixel of the frame.
   // NOTE: all outputs of this block are defaulted first to avoid latches.
   always_comb begin
      state_nxt = state;
      hc_nxt    = '0;
      vc_nxt    = '0;
      unique case (state)
         ST_IDLE: begin
            if (in_run) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (frame_end) begin
               if (!in_run) state_nxt = ST_IDLE;
            end else if (hc == H_LAST) begin
               vc_nxt = vc + 1'b1;
            end else begin
               hc_nxt = hc + 1'b1;
               vc_nxt = vc;
            end
         end
      endcase
   end

   assign ha      = (hc >= H_ACT_LO) && (hc <= H_ACT_HI);
   assign va      = (vc >= V_ACT_LO) && (vc <= V_ACT_HI);
   assign pix_act = running && ha && va;

   // Stage 1: coordinates for the pixel source, one clock after the counters.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_pix_req <= 1'b0;
         out_pixelx  <= '0;
         out_pixely  <= '0;
         out_frame   <= '0;
      end else begin
         out_pix_req <= pix_act;
         out_pixelx  <= pix_act ? (hc - H_ACT_LO) : '0;
         out_pixely  <= pix_act ? (vc - V_ACT_LO) : '0;
         if (frame_end) out_frame <= out_frame + 1'b1;
      end
   end

   assign out_busy = running;

   // Stage 2: the same decode held back PREFETCH more clocks. Depth
   // PREFETCH+1 includes the stage-1 register, so PREFETCH=0 aligns with
   // out_pix_req. Leaving RUN simply lets the pipe drain.
   assign align_in = {
      pix_act,
      (running && (hc < H_SYNC_N)) ? HSYNC_POL : ~HSYNC_POL,
      (running && (vc < V_SYNC_N)) ? VSYNC_POL : ~VSYNC_POL,
      running && (hc == '0) && (vc == '0)
   };

   lcd_delay_line #(
      .WIDTH   (4),
      .DEPTH   (PREFETCH + 1),
      .RST_VAL (ALIGN_RST)
   ) u_align (
      .in_clk   (in_clk),
      .in_rst_n (in_rst_n),
      .in_data  (align_in),
      .out_data (align_out)
   );

   assign {out_en, out_hsync, out_vsync, out_ssync} = align_out;

endmodule

// File: tb/tb_tft_lcd_timing.sv
// ---------------------------------------------------------------------------
// tb_tft_lcd_timing
// Three instances share one clock:
//   dut a : small geometry (H 4/1/2/1, V 3/1/1/1), PREFETCH=0, active-low syncs
//   dut b : same geometry, PREFETCH=3, active-high syncs
//   dut c : default 480x272 geometry
// A reference model works on a linear pixel position within the frame and a
// history of decoded positions; each clock it predicts every output.
// ---------------------------------------------------------------------------
module tb_tft_lcd_timing;

   typedef struct packed {
      int ha; int hfp; int hs; int hbp;
      int va; int vfp; int vs; int vbp;
      int pf; bit hpol; bit vpol;
   } geom_t;

   typedef struct packed {
      bit req; logic [9:0] x; logic [9:0] y;
      bit en; bit hs; bit vs; bit ss;
   } dec_t;

   logic       clk = 1'b0;
   logic [2:0] run = 3'b000;
   logic [2:0] rst_n = 3'b111;

   logic       req_a, en_a, hs_a, vs_a, ss_a, busy_a;
   logic       req_b, en_b, hs_b, vs_b, ss_b, busy_b;
   logic       req_c, en_c, hs_c, vs_c, ss_c, busy_c;
   logic [9:0] px_a, py_a, px_b, py_b, px_c, py_c;
   logic [7:0] frm_a, frm_b, frm_c;

   always #5 clk = ~clk;

   tft_lcd_timing #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PREFETCH(0), .COORD_W(10), .FRAME_W(8)
   ) u_dut_a (
      .in_clk(clk), .in_rst_n(rst_n[0]), .in_run(run[0]),
      .out_pix_req(req_a), .out_pixelx(px_a), .out_pixely(py_a),
      .out_en(en_a), .out_hsync(hs_a), .out_vsync(vs_a), .out_ssync(ss_a),
      .out_frame(frm_a), .out_busy(busy_a)
   );

   tft_lcd_timing #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PREFETCH(3), .COORD_W(10), .FRAME_W(8)
   ) u_dut_b (
      .in_clk(clk), .in_rst_n(rst_n[1]), .in_run(run[1]),
      .out_pix_req(req_b), .out_pixelx(px_b), .out_pixely(py_b),
      .out_en(en_b), .out_hsync(hs_b), .out_vsync(vs_b), .out_ssync(ss_b),
      .out_frame(frm_b), .out_busy(busy_b)
   );

   tft_lcd_timing u_dut_c (
      .in_clk(clk), .in_rst_n(rst_n[2]), .in_run(run[2]),
      .out_pix_req(req_c), .out_pixelx(px_c), .out_pixely(py_c),
      .out_en(en_c), .out_hsync(hs_c), .out_vsync(vs_c), .out_ssync(ss_c),
      .out_frame(frm_c), .out_busy(busy_c)
   );

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   geom_t geo [3];
   bit    m_run [3];
   int    m_pos [3];
   int    m_frames [3];
   dec_t  hist [3][8];   // hist[k][n]: decode of the position n+1 clocks ago

   function automatic int h_total(input geom_t g);
      return g.hs + g.hbp + g.ha + g.hfp;
   endfunction

   function automatic int v_total(input geom_t g);
      return g.vs + g.vbp + g.va + g.vfp;
   endfunction

   function automatic dec_t decode(input geom_t g, input bit on, input int pos);
      dec_t d;
      int hc, vc, hst, vst;
      bit in_h, in_v;
      hc   = pos % h_total(g);
      vc   = pos / h_total(g);
      hst  = g.hs + g.hbp;
      vst  = g.vs + g.vbp;
      in_h = (hc >= hst) && (hc < hst + g.ha);
      in_v = (vc >= vst) && (vc < vst + g.va);
      d     = '0;
      d.req = on && in_h && in_v;
      d.en  = d.req;
      if (d.req) begin
         d.x = 10'(hc - hst);
         d.y = 10'(vc - vst);
      end
      d.hs = on && (hc < g.hs);
      d.vs = on && (vc < g.vs);
      d.ss = on && (pos == 0);
      return d;
   endfunction

   task automatic model_reset(input int k);
      m_run[k]    = 1'b0;
      m_pos[k]    = 0;
      m_frames[k] = 0;
      for (int i = 0; i < 8; i++) hist[k][i] = '0;
   endtask

   task automatic model_edge(input int k, input bit run_in, input bit rst_in);
      int flen;
      if (!rst_in) begin
         model_reset(k);
         return;
      end
      flen = h_total(geo[k]) * v_total(geo[k]);
      for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = decode(geo[k], m_run[k], m_pos[k]);
      if (!m_run[k]) begin
         if (run_in) begin
            m_run[k] = 1'b1;
            m_pos[k] = 0;
         end
      end else if (m_pos[k] == flen - 1) begin
         m_frames[k]++;
         m_pos[k] = 0;
         if (!run_in) m_run[k] = 1'b0;
      end else begin
         m_pos[k]++;
      end
   endtask

   function automatic logic [33:0] expect_vec(input int k);
      dec_t s1, s2;
      s1 = hist[k][0];
      s2 = hist[k][geo[k].pf];
      return {s1.req, s1.x, s1.y, s2.en,
              s2.hs ? geo[k].hpol : ~geo[k].hpol,
              s2.vs ? geo[k].vpol : ~geo[k].vpol,
              s2.ss, m_run[k], 8'(m_frames[k])};
   endfunction

   function automatic logic [33:0] obs_vec(input int k);
      case (k)
         0:       return {req_a, px_a, py_a, en_a, hs_a, vs_a, ss_a, busy_a, frm_a};
         1:       return {req_b, px_b, py_b, en_b, hs_b, vs_b, ss_b, busy_b, frm_b};
         default: return {req_c, px_c, py_c, en_c, hs_c, vs_c, ss_c, busy_c, frm_c};
      endcase
   endfunction

   // ---------------- per-clock stepping and scenario counters ----------------
   int cyc = 0;
   bit p1 = 1'b0;
   int a_en_cnt = 0, a_last_ss = -1;
   int b_req_rise = -100;
   bit b_prev_req = 1'b0, b_prev_en = 1'b0;
   int c_win = -1, c_hs_low = 0, c_vs_low = 0;

   task automatic step();
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_edge(k, run[k], rst_n[k]);
      #1;
      cyc++;
      for (int k = 0; k < 3; k++) check($sformatf("dut%0d.outputs", k), 64'(obs_vec(k)), 64'(expect_vec(k)));

      if (p1) begin
         if (en_a) a_en_cnt++;
         if (ss_a) begin
            if (a_last_ss >= 0) begin
               check("a.en_per_frame", 64'(a_en_cnt), 64'd12);
               check("a.ssync_period", 64'(cyc - a_last_ss), 64'd48);
            end
            a_last_ss = cyc;
            a_en_cnt  = 0;
         end
         if (req_b && !b_prev_req) b_req_rise = cyc;
         if (en_b && !b_prev_en) check("b.prefetch_lead", 64'(cyc - b_req_rise), 64'd3);
      end
      b_prev_req = req_b;
      b_prev_en  = en_b;

      if (ss_c && c_win == -1) begin
         c_win = 0; c_hs_low = 0; c_vs_low = 0;
      end
      if (c_win >= 0) begin
         if (c_win < 525 && !hs_c) c_hs_low++;
         if (!vs_c) c_vs_low++;
         c_win++;
         if (c_win == 525) check("c.hsync_low_per_line", 64'(c_hs_low), 64'd41);
         if (c_win == 6000) begin
            check("c.vsync_low_per_frame", 64'(c_vs_low), 64'd5250);
            c_win = -2;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n, f0, en_cnt;
      bit wrap_seen;
      logic [7:0] prev_frm;

      geo[0] = '{ha:4, hfp:1, hs:2, hbp:1, va:3, vfp:1, vs:1, vbp:1, pf:0, hpol:1'b0, vpol:1'b0};
      geo[1] = '{ha:4, hfp:1, hs:2, hbp:1, va:3, vfp:1, vs:1, vbp:1, pf:3, hpol:1'b1, vpol:1'b1};
      geo[2] = '{ha:480, hfp:2, hs:41, hbp:2, va:272, vfp:2, vs:10, vbp:2, pf:0, hpol:1'b0, vpol:1'b0};
      for (int k = 0; k < 3; k++) model_reset(k);

      // Reset state, before any clock edge.
      #1 rst_n = 3'b000;
      #2;
      for (int k = 0; k < 3; k++) check($sformatf("dut%0d.reset", k), 64'(obs_vec(k)), 64'(expect_vec(k)));
      check("b.reset_hsync_low", 64'(hs_b), 64'd0);
      check("a.reset_hsync_high", 64'(hs_a), 64'd1);
      repeat (3) step();

      // Free-running frames on all instances.
      rst_n = 3'b111;
      run   = 3'b111;
      p1    = 1'b1;
      repeat (600) step();
      p1    = 1'b0;

      // Stop request mid-frame at hc=2, vc=1: the frame must complete.
      n = 0;
      while (!(m_run[0] && m_pos[0] == 10) && n < 200) begin
         step();
         n++;
      end
      check("a.stop_point_reached", 64'(n < 200), 64'd1);
      run[0] = 1'b0;
      f0     = m_frames[0];
      en_cnt = 0;
      n      = 0;
      do begin
         step();
         if (en_a) en_cnt++;
         n++;
      end while (busy_a && n < 100);
      check("a.stop_timeout", 64'(n < 100), 64'd1);
      repeat (5) begin
         step();
         if (en_a) en_cnt++;
      end
      check("a.stop_en_count", 64'(en_cnt), 64'd12);
      check("a.stop_frame_inc", 64'(frm_a), 64'(8'(f0 + 1)));
      check("a.idle_en", 64'(en_a), 64'd0);
      check("a.idle_hsync", 64'(hs_a), 64'd1);
      check("a.idle_vsync", 64'(vs_a), 64'd1);
      run[0] = 1'b1;
      step();
      step();
      check("a.restart_ssync", 64'(ss_a), 64'd1);

      // Random run/stop traffic on the small-geometry instances.
      for (int i = 0; i < 150; i++) begin
         run[0] = ($urandom_range(0, 3) != 0);
         run[1] = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(1, 60)) step();
      end

      // Asynchronous reset in the middle of an active line.
      run[0] = 1'b1;
      n = 0;
      while (!en_a && n < 200) begin
         step();
         n++;
      end
      check("a.active_reached", 64'(n < 200), 64'd1);
      #2 rst_n[0] = 1'b0;
      model_reset(0);
      #1;
      check("a.async_rst_en", 64'(en_a), 64'd0);
      check("a.async_rst_hsync", 64'(hs_a), 64'd1);
      check("a.async_rst_frame", 64'(frm_a), 64'd0);
      check("a.async_rst_pix_req", 64'(req_a), 64'd0);
      run[0] = 1'b0;
      repeat (3) step();
      rst_n[0] = 1'b1;
      repeat (20) step();
      check("a.stays_idle", 64'(busy_a), 64'd0);

      // Long run on b: frame counter must wrap 255 -> 0.
      run[1]    = 1'b1;
      wrap_seen = 1'b0;
      prev_frm  = frm_b;
      for (int i = 0; i < 260 * 48 + 20; i++) begin
         if (i % 37 == 0) run[0] = 1'($urandom_range(0, 1));
         step();
         if (prev_frm == 8'd255 && frm_b == 8'd0) wrap_seen = 1'b1;
         prev_frm = frm_b;
      end
      check("b.frame_wrap_seen", 64'(wrap_seen), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
